// File: rtl/fib_sequencer.sv
// fib_sequencer
//   Controller for the Fibonacci term datapath. After an accepted start it
//   loads the two term registers with 1, 1. It then emits one term per cycle
//   (1, 1, 2, 3, 5, ...) until n_terms terms have been produced, and pulses
//   done. hold stalls progress while in RUN. A sticky ovf flag records that a
//   term which wrapped modulo 2^WIDTH was reached.
//
//   Optional feature macro: FIB_OVF_STOP_EN
//     defined   - the first wrapped term is suppressed, ovf is set and the
//                 sequence ends early through DONE.
//     undefined - wrapped terms are emitted modulo 2^WIDTH and the sequence
//                 runs to the requested count.
//
// Ports
//   clk        in   1      clock, all state on posedge
//   reset      in   1      synchronous active-high reset
//   start      in   1      request a new sequence (only honoured in IDLE)
//   n_terms    in   CNT_W  number of terms, captured with the accepted start
//   hold       in   1      stall while in RUN
//   term       out  WIDTH  current term value (register a)
//   term_valid out  1      term is valid this cycle (combinational from hold)
//   busy       out  1      high in LOAD and RUN
//   done       out  1      one-cycle completion pulse
//   ovf        out  1      sticky wrap flag, cleared on the next accepted start
module fib_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             hold,
  output logic [WIDTH-1:0] term,
  output logic             term_valid,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             aw_q, aw_d, bw_q, bw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nlat_q, nlat_d;
  logic             ovf_q, ovf_d;

  // Extra bit holds the carry out of the term addition.
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] last_cnt;
  logic             stop_hit;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign last_cnt = nlat_q - CNT_W'(1);

  // stop_hit marks a RUN cycle whose term must be swallowed rather than
  // emitted; it can only be set when early stop on wrap is built in.
`ifdef FIB_OVF_STOP_EN
  assign stop_hit = aw_q;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      aw_q    <= 1'b0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      nlat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aw_q    <= aw_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      nlat_q  <= nlat_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    aw_d    = aw_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    nlat_d  = nlat_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (n_terms != '0) begin
            nlat_d  = n_terms;
            state_d = S_LOAD;
          end else begin
            // Empty request: complete the handshake without emitting.
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        a_d     = WIDTH'(1);
        b_d     = WIDTH'(1);
        aw_d    = 1'b0;
        bw_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!hold) begin
          if (aw_q) ovf_d = 1'b1;
          if (stop_hit) begin
            state_d = S_DONE;
          end else begin
            a_d   = b_q;
            aw_d  = bw_q;
            b_d   = sum[WIDTH-1:0];
            // Wrap is inherited: once any operand wrapped, so do all
            // later terms, even if the truncated sum happens not to carry.
            bw_d  = sum[WIDTH] | aw_q | bw_q;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == last_cnt) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign term       = a_q;
  assign term_valid = (state_q == S_RUN) & ~hold & ~stop_hit;
  assign busy       = (state_q == S_LOAD) | (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fib_sequencer.sv
module tb_fib_sequencer;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] n_terms;
  logic          hold;
  logic [W-1:0]  term;
  logic          term_valid;
  logic          busy;
  logic          done;
  logic          ovf;

  int n_asserts = 0;
  int n_fail    = 0;
  int done_total = 0;
  bit mon_en    = 1'b0;

  logic [W-1:0] sb[$];

  fib_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_terms    (n_terms),
    .hold       (hold),
    .term       (term),
    .term_valid (term_valid),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected terms from the true integer Fibonacci series; a term at or
  // above 2^W is a wrapped one and shows up truncated.
  task automatic push_seq(input int n);
    int f0 = 1;
    int f1 = 1;
    int t;
    for (int i = 0; i < n; i++) begin
`ifdef FIB_OVF_STOP_EN
      if (f0 >= (1 << W)) break;
`endif
      sb.push_back(W'(f0 % (1 << W)));
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("done_valid_excl", {63'd0, done & term_valid}, 64'd0);
      if (done) done_total++;
      if (term_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_term", 64'(sb.size()), 64'd1);
        end else begin
          check("term_value", {60'd0, term}, {60'd0, sb.pop_front()});
        end
      end
    end
  end

  // Cycle 0 is the cycle in which start is first presented. Returns the cycle
  // of the done pulse and per-cycle masks of busy and term_valid.
  task automatic run_seq(input int n, input int hold_lo, input int hold_hi,
                         input logic [63:0] start_mask,
                         output int done_cyc, output logic [63:0] bmask,
                         output logic [63:0] vmask);
    done_cyc = -1;
    bmask    = '0;
    vmask    = '0;
    push_seq(n);
    n_terms  = CW'(n);
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      start = (c == 0) ? 1'b1 : start_mask[c];
      hold  = (c >= hold_lo) && (c <= hold_hi);
      @(negedge clk);
      bmask[c] = busy;
      vmask[c] = term_valid;
      if (done) done_cyc = c;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  int          dc;
  logic [63:0] bm, vm;
  int          dbase;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    n_terms = '0;
    hold    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_term", {60'd0, term}, 64'd0);
    check("rst_valid", {63'd0, term_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Basic six-term run.
    run_seq(6, 99, 99, 64'd0, dc, bm, vm);
    check("n6_done_cyc", 64'(dc), 64'd8);
    check("n6_busy_mask", bm, 64'h0FE);
    check("n6_valid_mask", vm, 64'h0FC);
    check("n6_ovf", {63'd0, ovf}, 64'd0);
    check("n6_sb_empty", 64'(sb.size()), 64'd0);

    // Wrap-around run.
    run_seq(9, 99, 99, 64'd0, dc, bm, vm);
`ifdef FIB_OVF_STOP_EN
    check("n9_done_cyc", 64'(dc), 64'd10);
    check("n9_valid_mask", vm, 64'h1FC);
`else
    check("n9_done_cyc", 64'(dc), 64'd11);
    check("n9_valid_mask", vm, 64'h7FC);
`endif
    check("n9_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("n9_ovf_sticky", {63'd0, ovf}, 64'd1);
    @(posedge clk);
    #1;

    // Hold in cycles 3-4.
    run_seq(4, 3, 4, 64'd0, dc, bm, vm);
    check("hold_done_cyc", 64'(dc), 64'd8);
    check("hold_valid_mask", vm, 64'h0E4);
    check("hold_sb_empty", 64'(sb.size()), 64'd0);

    // Empty request.
    run_seq(0, 99, 99, 64'd0, dc, bm, vm);
    check("n0_done_cyc", 64'(dc), 64'd1);
    check("n0_valid_mask", vm, 64'd0);
    check("n0_busy_mask", bm, 64'd0);
    check("n0_ovf", {63'd0, ovf}, 64'd0);

    // Start pulses while busy and in DONE are ignored.
    dbase = done_total;
    run_seq(5, 99, 99, 64'h0AA, dc, bm, vm);
    check("ign_done_cyc", 64'(dc), 64'd7);
    check("ign_valid_mask", vm, 64'h07C);
    repeat (4) @(posedge clk);
    #1;
    check("ign_done_count", 64'(done_total - dbase), 64'd1);
    check("ign_sb_empty", 64'(sb.size()), 64'd0);
    check("ign_busy_after", {63'd0, busy}, 64'd0);

    // Reset in cycle 4 of a ten-term run: terms of cycles 2..4 only.
    push_seq(3);
    n_terms = CW'(10);
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      reset = (c == 4);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("mrst_term", {60'd0, term}, 64'd0);
    check("mrst_valid", {63'd0, term_valid}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    check("mrst_ovf", {63'd0, ovf}, 64'd0);
    check("mrst_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
    run_seq(3, 99, 99, 64'd0, dc, bm, vm);
    check("post_rst_done_cyc", 64'(dc), 64'd5);
    check("post_rst_valid_mask", vm, 64'h01C);
    check("post_rst_ovf", {63'd0, ovf}, 64'd0);
    check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Controller for the hierarchical Fibonacci datapath. It sequences the two term registers and the adder to emit a requested number of Fibonacci terms (1, 1, 2, 3, 5, …), one per cycle, under a start/done handshake. Downstream logic can stall it with a hold input, and it flags arithmetic wrap-around. It sits between the top-level control logic and the term-storage/adder datapath.

## Interface
Parameters:
- WIDTH, 4: term width in bits (datapath register width).
- CNT_W, 4: width of the term-count request; up to 2^CNT_W−1 terms.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- start  in  1  request a new sequence; sampled only in IDLE.
- n_terms  in  CNT_W  number of terms to emit; captured on the accepted start.
- hold  in  1  stall; freezes RUN progress while high.
- term  out  WIDTH  current term value.
- term_valid  out  1  term is valid this cycle.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse on sequence completion.
- ovf  out  1  sticky wrap flag; cleared on the next accepted start.

## Operation
- Internal state: a and b (WIDTH each, current and next term); a_w and b_w (wrap tags); cnt (CNT_W); n_lat (CNT_W).
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: busy=0.
  - start=1 with n_terms≠0: latch n_lat, clear ovf, go to LOAD.
  - start=1 with n_terms=0: clear ovf, go to DONE; no terms are emitted.
- LOAD: a←1, b←1, a_w←0, b_w←0, cnt←0, go to RUN.
- RUN with hold=0: term_valid=1 and term=a.
  - Update a←b, a_w←b_w, b←(a+b) mod 2^WIDTH.
  - b_w←carry_out(a+b) | a_w | b_w. Once a value has wrapped, every later term is tagged as wrapped.
  - cnt←cnt+1.
  - If the emitted term had a_w=1, ovf←1.
  - If cnt==n_lat−1 (last term), go to DONE.
- RUN with hold=1: term_valid=0; a, b, the tags and cnt are frozen; term still shows a.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- A start seen outside IDLE is ignored and not queued.
- term_valid = (state==RUN) & ~hold. This output is combinational from hold; all other outputs come straight from registers.

## Timing
- Reset values: state=IDLE, a=b=0, tags=0, cnt=0, term=0, term_valid=0, busy=0, done=0, ovf=0.
- Reset has priority over every other input at any point, including mid-RUN. Outputs show reset values in the cycle after reset is sampled high.
- Start latency: start accepted at edge k → LOAD during cycle k+1 → first term_valid during cycle k+2.
- With no hold, N terms are valid on consecutive cycles k+2 … k+N+1, and done pulses in cycle k+N+2.
- Each hold cycle during RUN adds exactly one cycle of latency; sequence values are not lost or repeated.
- hold in states other than RUN has no effect.
- done and term_valid are never high in the same cycle.
- The earliest next start is accepted in the cycle after done, when the FSM is back in IDLE.

## Configuration
- FIB_OVF_STOP_EN defined: when RUN would emit a term with a_w=1, it does not emit it.
  - term_valid=0 that cycle, ovf←1, and the FSM goes to DONE.
  - Only non-wrapped terms are ever output.
- FIB_OVF_STOP_EN undefined: wrapped terms are emitted modulo 2^WIDTH, ovf is set, and the sequence runs to n_lat terms.

## Test plan
- WIDTH=4, n_terms=6, start at cycle 0 → term_valid in cycles 2–7 with terms 1,1,2,3,5,8; done in cycle 8; ovf=0; busy high in cycles 1–7.
- n_terms=9, macro undefined → terms 1,1,2,3,5,8,13,5,2; ovf rises with the term 5 (eighth term) and stays high after done.
- n_terms=9, FIB_OVF_STOP_EN defined → terms 1,1,2,3,5,8,13 only; ovf=1; done one cycle after the 13.
- n_terms=4, hold high in cycles 3–4 → valid terms 1 (cycle 2), 1 (cycle 5), 2 (cycle 6), 3 (cycle 7); done in cycle 8.
- n_terms=0 → done in cycle 1, no term_valid. Then start pulses while busy on an n_terms=5 run → ignored, exactly 5 terms, one done.
- reset at cycle 4 of an n_terms=10 run → all outputs 0 from cycle 5. A new start with n_terms=3 then produces 1,1,2 with ovf=0.
